// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: imem request/response, hazard controls, redirect and IF/ID latch outputs.
// Latency: none (wires only).
// Backpressure: imem stalls via ihit; hazard unit stalls via disable_fetch.
interface fetch_stage_if;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] imemaddr;
    logic        disable_fetch;
    logic        flush2;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        halt;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
    logic        ifid_valid;

    // Fetch stage side
    modport slave (
        input  ihit, imemload, disable_fetch, flush2, redirect, redirect_target, halt,
        output iREN, imemaddr, ifid_instr, ifid_npc, ifid_valid
    );

    // Environment side: memory, hazard unit, downstream stages
    modport master (
        output ihit, imemload, disable_fetch, flush2, redirect, redirect_target, halt,
        input  iREN, imemaddr, ifid_instr, ifid_npc, ifid_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, imem request, one-entry skid buffer, pending redirect, IF/ID latch.
// Latency: one cycle from ihit to IF/ID.
// Backpressure: disable_fetch parks a returned word in the skid buffer; iREN drops while it is full.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic          CLK,
    input  logic          nRST,
    fetch_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        BUFFERED = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_npc_q, ifid_npc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_npc_q, buf_npc_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pc_inc;
    logic        bubble;

    // Sequential fetch address; wraps modulo 2^32
    assign pc_inc = pc_q + PC_STEP;

    assign bus.iREN       = (state_q == FETCH) || (state_q == DRAIN);
    assign bus.imemaddr   = pc_q;
    assign bus.ifid_instr = ifid_instr_q;
    assign bus.ifid_npc   = ifid_npc_q;
    assign bus.ifid_valid = ifid_valid_q;

    // Next-state: halt > redirect > flush2 > disable_fetch > normal fetch
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_npc_d    = ifid_npc_q;
        ifid_valid_d  = ifid_valid_q;
        buf_instr_d   = buf_instr_q;
        buf_npc_d     = buf_npc_q;
        pend_target_d = pend_target_q;
        pend_valid_d  = pend_valid_q;
        bubble        = 1'b0;

        if (state_q == HALTED) begin
            // Terminal until reset
            state_d = HALTED;
        end else if (bus.halt) begin
            state_d      = HALTED;
            bubble       = 1'b1;
            pend_valid_d = 1'b0;
        end else if (bus.redirect) begin
            bubble = 1'b1;
            if (state_q == FETCH && !bus.ihit) begin
                // Let the outstanding access finish at the old pc, then jump
                pend_target_d = bus.redirect_target;
                pend_valid_d  = 1'b1;
                state_d       = DRAIN;
            end else if (state_q == DRAIN && !bus.ihit) begin
                // Newer redirect replaces the parked one
                pend_target_d = bus.redirect_target;
            end else begin
                // Access complete (or none in flight): jump now, drop word and buffer
                pc_d         = bus.redirect_target;
                pend_valid_d = 1'b0;
                state_d      = FETCH;
            end
        end else if (state_q == DRAIN) begin
            if (bus.flush2) begin
                bubble = 1'b1;
            end
            if (bus.ihit && pend_valid_q) begin
                // Discard the stale word and resume at the redirect target
                pc_d         = pend_target_q;
                pend_valid_d = 1'b0;
                state_d      = FETCH;
            end
        end else if (bus.flush2) begin
            bubble = 1'b1;
            if (state_q == BUFFERED) begin
                // Buffered word is squashed; refetch it from its own pc
                pc_d    = buf_npc_q - PC_STEP;
                state_d = FETCH;
            end
        end else if (bus.disable_fetch) begin
            if (state_q == FETCH && bus.ihit) begin
                buf_instr_d = bus.imemload;
                buf_npc_d   = pc_inc;
                pc_d        = pc_inc;
                state_d     = BUFFERED;
            end
        end else if (state_q == BUFFERED) begin
            ifid_instr_d = buf_instr_q;
            ifid_npc_d   = buf_npc_q;
            ifid_valid_d = 1'b1;
            state_d      = FETCH;
        end else if (bus.ihit) begin
            ifid_instr_d = bus.imemload;
            ifid_npc_d   = pc_inc;
            ifid_valid_d = 1'b1;
            pc_d         = pc_inc;
        end else begin
            // No word arrived and nothing stalls the pipe: insert a bubble
            bubble = 1'b1;
        end

        if (bubble) begin
            ifid_instr_d = 32'h0;
            ifid_npc_d   = 32'h0;
            ifid_valid_d = 1'b0;
        end
    end

    // State, PC, skid buffer, pending redirect and IF/ID registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= FETCH;
            pc_q          <= PC_INIT;
            ifid_instr_q  <= 32'h0;
            ifid_npc_q    <= 32'h0;
            ifid_valid_q  <= 1'b0;
            buf_instr_q   <= 32'h0;
            buf_npc_q     <= 32'h0;
            pend_target_q <= 32'h0;
            pend_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_npc_q    <= ifid_npc_d;
            ifid_valid_q  <= ifid_valid_d;
            buf_instr_q   <= buf_instr_d;
            buf_npc_q     <= buf_npc_d;
            pend_target_q <= pend_target_d;
            pend_valid_q  <= pend_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed stimulus, IF/ID scoreboard, direct pc/iREN checks.
// Latency: expects IF/ID one cycle after an accepted ihit.
// Backpressure: drives disable_fetch/flush2/redirect/halt combinations against the skid buffer.
module tb_fetch_stage;

    logic CLK = 1'b0;
    logic nRST;

    always #5 CLK = ~CLK;

    fetch_stage_if bus();

    fetch_stage #(
        .PC_INIT (32'h0000_0000),
        .PC_STEP (32'd4)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.ihit            = 1'b0;
        bus.imemload        = 32'h0;
        bus.disable_fetch   = 1'b0;
        bus.flush2          = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = 32'h0;
        bus.halt            = 1'b0;
    endtask

    task automatic expect_ifid(input logic [31:0] instr, input logic [31:0] npc);
        sb_q.push_back({instr, npc});
    endtask

    // Monitor: each newly latched valid IF/ID entry must match the scoreboard head
    logic        prev_valid = 1'b0;
    logic [31:0] prev_instr = 32'h0;
    logic [31:0] prev_npc   = 32'h0;
    always @(negedge CLK) begin
        logic [63:0] exp;
        if (!nRST) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.ifid_valid && (!prev_valid || bus.ifid_instr !== prev_instr ||
                                   bus.ifid_npc !== prev_npc)) begin
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    exp = sb_q.pop_front();
                    check("ifid_instr", bus.ifid_instr, exp[63:32]);
                    check("ifid_npc", bus.ifid_npc, exp[31:0]);
                end
            end
            prev_valid = bus.ifid_valid;
            prev_instr = bus.ifid_instr;
            prev_npc   = bus.ifid_npc;
        end
    end

    initial begin
        idle();
        nRST = 1'b0;
        repeat (3) tick();
        check("rst_addr", bus.imemaddr, 32'h0);
        check("rst_iren", 32'(bus.iREN), 32'd1);
        check("rst_valid", 32'(bus.ifid_valid), 32'd0);
        check("rst_instr", bus.ifid_instr, 32'h0);
        check("rst_npc", bus.ifid_npc, 32'h0);
        nRST = 1'b1;

        // Sequential fetch
        bus.ihit = 1'b1; bus.imemload = 32'h2001_0005;
        expect_ifid(32'h2001_0005, 32'h4);
        tick();
        check("seq_addr1", bus.imemaddr, 32'h4);
        check("seq_valid", 32'(bus.ifid_valid), 32'd1);
        bus.imemload = 32'h2002_0007;
        expect_ifid(32'h2002_0007, 32'h8);
        tick();
        check("seq_addr2", bus.imemaddr, 32'h8);

        // Stall with skid buffer capture
        bus.imemload = 32'h1234_5678; bus.disable_fetch = 1'b1;
        tick();
        check("stall_iren", 32'(bus.iREN), 32'd0);
        check("stall_hold_npc", bus.ifid_npc, 32'h8);
        bus.ihit = 1'b0; bus.imemload = 32'h0;
        repeat (2) tick();
        check("stall_hold_instr", bus.ifid_instr, 32'h2002_0007);
        check("stall_iren2", 32'(bus.iREN), 32'd0);
        check("stall_addr", bus.imemaddr, 32'hC);
        bus.disable_fetch = 1'b0;
        expect_ifid(32'h1234_5678, 32'hC);
        tick();
        check("unstall_valid", 32'(bus.ifid_valid), 32'd1);
        check("unstall_addr", bus.imemaddr, 32'hC);
        check("unstall_iren", 32'(bus.iREN), 32'd1);

        bus.ihit = 1'b1; bus.imemload = 32'h0000_0020;
        expect_ifid(32'h0000_0020, 32'h10);
        tick();
        check("seq_addr3", bus.imemaddr, 32'h10);

        // Redirect while the access at 0x10 is outstanding
        bus.ihit = 1'b0; bus.redirect = 1'b1; bus.redirect_target = 32'h40;
        tick();
        check("drain_addr", bus.imemaddr, 32'h10);
        check("drain_valid", 32'(bus.ifid_valid), 32'd0);
        check("drain_iren", 32'(bus.iREN), 32'd1);
        bus.redirect = 1'b0;
        tick();
        check("drain_hold_addr", bus.imemaddr, 32'h10);
        bus.ihit = 1'b1; bus.imemload = 32'hDEAD_BEEF;
        tick();
        check("drain_done_addr", bus.imemaddr, 32'h40);
        check("drain_drop_valid", 32'(bus.ifid_valid), 32'd0);

        // Redirect, flush2 and disable_fetch together with ihit
        bus.imemload = 32'h1111_1111; bus.redirect = 1'b1; bus.redirect_target = 32'h100;
        bus.flush2 = 1'b1; bus.disable_fetch = 1'b1;
        tick();
        check("combo_addr", bus.imemaddr, 32'h100);
        check("combo_iren", 32'(bus.iREN), 32'd1);
        check("combo_valid", 32'(bus.ifid_valid), 32'd0);
        bus.redirect = 1'b0; bus.flush2 = 1'b0; bus.disable_fetch = 1'b0;
        bus.imemload = 32'h2222_2222;
        expect_ifid(32'h2222_2222, 32'h104);
        tick();
        check("combo_next_addr", bus.imemaddr, 32'h104);

        // flush2 alone at 0x20 refetches
        bus.redirect = 1'b1; bus.redirect_target = 32'h20; bus.imemload = 32'h0;
        tick();
        bus.redirect = 1'b0;
        check("redir_addr", bus.imemaddr, 32'h20);
        bus.flush2 = 1'b1; bus.imemload = 32'h3333_3333;
        tick();
        check("flush_addr", bus.imemaddr, 32'h20);
        check("flush_valid", 32'(bus.ifid_valid), 32'd0);
        bus.flush2 = 1'b0; bus.imemload = 32'h4444_4444;
        expect_ifid(32'h4444_4444, 32'h24);
        tick();
        check("refetch_addr", bus.imemaddr, 32'h24);

        // flush2 discards a full skid buffer
        bus.disable_fetch = 1'b1; bus.imemload = 32'h5555_5555;
        tick();
        check("buf_iren", 32'(bus.iREN), 32'd0);
        check("buf_addr", bus.imemaddr, 32'h28);
        bus.ihit = 1'b0; bus.flush2 = 1'b1;
        tick();
        check("bufflush_addr", bus.imemaddr, 32'h24);
        check("bufflush_iren", 32'(bus.iREN), 32'd1);
        check("bufflush_valid", 32'(bus.ifid_valid), 32'd0);
        bus.flush2 = 1'b0; bus.disable_fetch = 1'b0;

        // Second redirect while draining overwrites the target
        bus.redirect = 1'b1; bus.redirect_target = 32'h80;
        tick();
        bus.redirect_target = 32'h90;
        tick();
        bus.redirect = 1'b0; bus.ihit = 1'b1; bus.imemload = 32'hCAFE_F00D;
        tick();
        check("dbl_redir_addr", bus.imemaddr, 32'h90);
        check("dbl_redir_valid", 32'(bus.ifid_valid), 32'd0);

        // PC wrap at the top of the address space
        bus.redirect = 1'b1; bus.redirect_target = 32'hFFFF_FFFC;
        tick();
        bus.redirect = 1'b0;
        check("wrap_start", bus.imemaddr, 32'hFFFF_FFFC);
        bus.imemload = 32'h6666_6666;
        expect_ifid(32'h6666_6666, 32'h0);
        tick();
        check("wrap_addr", bus.imemaddr, 32'h0);
        check("wrap_valid", 32'(bus.ifid_valid), 32'd1);
        bus.imemload = 32'h7777_7777;
        expect_ifid(32'h7777_7777, 32'h4);
        tick();
        check("post_wrap_addr", bus.imemaddr, 32'h4);

        // Halt is terminal
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        check("halt_iren", 32'(bus.iREN), 32'd0);
        check("halt_valid", 32'(bus.ifid_valid), 32'd0);
        bus.redirect = 1'b1; bus.redirect_target = 32'h40; bus.imemload = 32'h9999_9999;
        repeat (3) tick();
        bus.redirect = 1'b0;
        check("halted_iren", 32'(bus.iREN), 32'd0);
        check("halted_addr", bus.imemaddr, 32'h4);
        check("halted_valid", 32'(bus.ifid_valid), 32'd0);

        // Reset while halted, with a stray ihit during reset
        nRST = 1'b0; bus.ihit = 1'b1; bus.imemload = 32'hBAD0_BAD0;
        #2;
        check("rst2_addr", bus.imemaddr, 32'h0);
        check("rst2_iren", 32'(bus.iREN), 32'd1);
        tick();
        bus.ihit = 1'b0;
        nRST = 1'b1;
        tick();
        check("post_rst_addr", bus.imemaddr, 32'h0);
        check("post_rst_iren", 32'(bus.iREN), 32'd1);
        check("post_rst_valid", 32'(bus.ifid_valid), 32'd0);
        bus.ihit = 1'b1; bus.imemload = 32'h8888_8888;
        expect_ifid(32'h8888_8888, 32'h4);
        tick();
        check("final_addr", bus.imemaddr, 32'h4);

        idle();
        @(negedge CLK);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- PC register, instruction-memory request logic and IF/ID pipeline latch of the 5-stage MIPS pipeline.
- Sits directly upstream of the hazard unit and consumes its fetch-stall and IF/ID-flush outputs.
- Accepts resolved branch/jump redirects from later stages.
- Owns a one-entry skid buffer and a pending-redirect register so a redirect never breaks an in-flight imem access.

Parameters:
- PC_INIT, 32'h0000_0000, PC value after reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- CLK  input  1  pipeline clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- ihit  input  1  instruction memory: imemload valid this cycle.
- imemload  input  32  instruction word returned by memory.
- iREN  output  1  instruction read request.
- imemaddr  output  32  fetch address; equals pc.
- disable_fetch  input  1  hazard unit stall: hold PC and IF/ID.
- flush2  input  1  hazard unit: squash IF/ID to a bubble.
- redirect  input  1  branch taken or jump resolved downstream.
- redirect_target  input  32  new PC for redirect.
- halt  input  1  halt reached downstream; stop fetching.
- ifid_instr  output  32  latched instruction.
- ifid_npc  output  32  latched fetch PC + PC_STEP.
- ifid_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset, asynchronous and active-low: pc=PC_INIT, state=FETCH, ifid_instr=0, ifid_npc=0, ifid_valid=0, buffer empty, pend_valid=0.
- iREN: 1 only in FETCH and DRAIN.
- imemaddr: always pc.
- pc must stay stable while iREN=1 and ihit=0.
- Event priority per cycle: halt > redirect > flush2 > disable_fetch > normal fetch.
- FETCH, ihit=1, no other event: IF/ID <= {imemload, pc+PC_STEP, 1}; pc <= pc+PC_STEP. Latency one cycle from ihit to IF/ID.
- FETCH, ihit=1, disable_fetch=1: capture imemload and pc+PC_STEP in buffer; pc <= pc+PC_STEP; IF/ID held; go BUFFERED.
- FETCH, ihit=0, disable_fetch=1: IF/ID held; request stays up.
- BUFFERED: iREN=0. When disable_fetch=0, move buffer into IF/ID with valid=1 and go FETCH.
- redirect, FETCH with ihit=1 or BUFFERED: discard returned word and buffer; pc <= redirect_target; IF/ID <= bubble; go FETCH.
- redirect, FETCH with ihit=0: store target in pend_target, set pend_valid; IF/ID <= bubble; go DRAIN. pc unchanged so the access completes.
- DRAIN: on ihit, discard word, pc <= pend_target, clear pend_valid, go FETCH.
- DRAIN, second redirect before ihit: overwrites pend_target.
- flush2 without redirect: IF/ID <= bubble. Any ihit word that cycle is discarded and pc is not advanced (refetch). A full buffer is also discarded (BUFFERED -> FETCH, pc <= buffered npc - PC_STEP).
- flush2 with disable_fetch: flush wins; IF/ID becomes bubble.
- halt: go HALTED; IF/ID <= bubble; iREN=0. HALTED is terminal until nRST.
- Bubble: instr=0 (sll $0 nop), npc=0, valid=0.
- Arithmetic: pc+PC_STEP is modulo 2^32; 32'hFFFF_FFFC wraps to 0 with no flag.
- Reset mid-access: state returns to FETCH, PC_INIT is requested on the first cycle after release, and any late ihit is ignored.

Test Plan:
- Sequential fetch: reset, ihit every cycle, imemload=0x2001_0005 then 0x2002_0007 -> IF/ID npc 4 then 8, valid=1, imemaddr 0,4,8.
- Stall with buffer: disable_fetch=1 for 3 cycles while ihit returns 0x1234_5678 at pc=8 -> IF/ID unchanged, iREN=0 after capture. Release -> IF/ID={0x1234_5678, 0xC, 1}, next imemaddr=0xC.
- Redirect during outstanding access: redirect to 0x40 at pc=0x10 with ihit=0, ihit 2 cycles later -> imemaddr stays 0x10, returned word dropped, next imemaddr=0x40, ifid_valid=0.
- Redirect vs flush2 vs disable_fetch asserted together with ihit -> pc=redirect_target, IF/ID bubble, no buffer capture.
- flush2 alone with ihit at pc=0x20 -> IF/ID bubble, imemaddr stays 0x20 and refetches.
- halt -> iREN=0 forever, ifid_valid=0; nRST low mid-HALTED -> imemaddr=PC_INIT, iREN=1 after release.
